mem_tag_responder: RTL and testbench

//  Memory-side responder for the tagged processor bus driven by the instruction cache and data cache front-ends.

---
 rtl/mem_tag_responder.sv | 111 +++++++++++
 tb/tb_mem_tag_responder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mem_tag_responder.sv
// Tagged memory endpoint: grants a 4-bit tag per accepted LOAD/STORE and returns tag+payload LATENCY cycles later.
// Optional reject injection (LFSR-driven) is enabled by defining MEM_TAG_RESPONDER_REJECT_INJECT_EN.
module mem_tag_responder #(
    parameter int XLEN      = 32,
    parameter int MEM_DEPTH = 8192,
    parameter int LATENCY   = 4,
    parameter int NUM_TAGS  = 15
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      proc2mem_command,
    input  logic [XLEN-1:0] proc2mem_addr,
    input  logic [63:0]     proc2mem_data,
    output logic [3:0]      mem2proc_response,
    output logic [63:0]     mem2proc_data,
    output logic [3:0]      mem2proc_tag
);
    localparam int         AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    logic [63:0]        r_mem [MEM_DEPTH];
    logic [NUM_TAGS:1]  r_busy;
    logic [LATENCY-1:0] r_pv;
    logic [3:0]         r_ptag [LATENCY];
    logic [63:0]        r_pdat [LATENCY];

    logic [XLEN-4:0] w_blk;
    logic [AW-1:0]   w_idx;
    logic            w_in_range;
    logic            w_is_store;
    logic            w_cmd_ok;
    logic            w_inject;
    logic            w_accept;
    logic [3:0]      w_free_tag;
    logic [63:0]     w_payload;
    logic            w_unused;

    assign w_unused   = ^proc2mem_addr[2:0];
    assign w_blk      = proc2mem_addr[XLEN-1:3];
    assign w_idx      = w_blk[AW-1:0];
    assign w_in_range = w_blk < (XLEN-3)'(MEM_DEPTH);
    assign w_is_store = (proc2mem_command == BUS_STORE);
    assign w_cmd_ok   = (proc2mem_command == BUS_LOAD) || w_is_store;

`ifdef MEM_TAG_RESPONDER_REJECT_INJECT_EN
    logic [7:0] r_lfsr;

    // x^8+x^6+x^5+x^4+1, shifting toward the MSB
    always_ff @(posedge clock) begin
        if (reset) r_lfsr <= 8'h01;
        else       r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
    assign w_inject = r_lfsr[0];
`else
    assign w_inject = 1'b0;
`endif

    // Lowest-numbered free tag wins; the tag completing this cycle is still busy.
    always_comb begin
        w_free_tag = '0;
        for (int i = NUM_TAGS; i >= 1; i--) begin
            if (!r_busy[i]) w_free_tag = 4'(i);
        end
    end

    assign w_accept          = !reset && w_cmd_ok && w_in_range && (w_free_tag != 4'd0) && !w_inject;
    assign mem2proc_response = w_accept ? w_free_tag : 4'd0;
    assign w_payload         = w_is_store ? proc2mem_data : r_mem[w_idx];

    // Backing array is deliberately not reset.
    always_ff @(posedge clock) begin
        if (w_accept && w_is_store) r_mem[w_idx] <= proc2mem_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            for (int i = 1; i <= NUM_TAGS; i++) begin
                if (w_accept && (w_free_tag == 4'(i)))
                    r_busy[i] <= 1'b1;
                else if (r_pv[LATENCY-1] && (r_ptag[LATENCY-1] == 4'(i)))
                    r_busy[i] <= 1'b0;
            end
        end
    end

    // Empty stages carry tag 0 / data 0 so the outputs idle at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pv <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_ptag[i] <= '0;
                r_pdat[i] <= '0;
            end
        end else begin
            r_pv[0]   <= w_accept;
            r_ptag[0] <= w_accept ? w_free_tag : 4'd0;
            r_pdat[0] <= w_accept ? w_payload : 64'd0;
            for (int i = 1; i < LATENCY; i++) begin
                r_pv[i]   <= r_pv[i-1];
                r_ptag[i] <= r_ptag[i-1];
                r_pdat[i] <= r_pdat[i-1];
            end
        end
    end

    assign mem2proc_tag  = r_ptag[LATENCY-1];
    assign mem2proc_data = r_pdat[LATENCY-1];
endmodule

// File: tb/tb_mem_tag_responder.sv
// Scoreboard bench for mem_tag_responder: the driver queues expected responses/completions, a negedge monitor checks them.
module tb_mem_tag_responder;
    localparam int LAT = 4;
    localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;

    typedef struct {
        int          due;
        logic [3:0]  tag;
        logic [63:0] data;
    } cmp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  resp_a, tag_a, resp_b, tag_b;
    logic [63:0] data_a, data_b;
    logic        sel;
    logic [3:0]  w_resp, w_tag;
    logic [63:0] w_data;

    int          cnt = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  m_lfsr = 8'h01;
    logic [3:0]  q_resp[$];
    cmp_t        q_cmp[$];

    mem_tag_responder #(.XLEN(32), .MEM_DEPTH(8192), .LATENCY(LAT), .NUM_TAGS(15)) u_a (
        .clock(clock), .reset(reset), .proc2mem_command(proc2mem_command),
        .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
        .mem2proc_response(resp_a), .mem2proc_data(data_a), .mem2proc_tag(tag_a));

    mem_tag_responder #(.XLEN(32), .MEM_DEPTH(8192), .LATENCY(LAT), .NUM_TAGS(2)) u_b (
        .clock(clock), .reset(reset), .proc2mem_command(proc2mem_command),
        .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
        .mem2proc_response(resp_b), .mem2proc_data(data_b), .mem2proc_tag(tag_b));

    assign w_resp = sel ? resp_b : resp_a;
    assign w_tag  = sel ? tag_b  : tag_a;
    assign w_data = sel ? data_b : data_a;

    always #5 clock = ~clock;
    always @(posedge clock) cnt <= cnt + 1;

    function automatic logic [63:0] dk(input int k);
        return {32'hA5A5_0000 + 32'(k), 32'h3C3C_1000 ^ 32'(k)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cnt, act, exp);
        end
    endtask

    // One bus cycle: drive, queue expectations, advance to just after the next edge.
    task automatic cyc(input logic [1:0] cmd, input logic [31:0] addr, input logic [63:0] data,
                       input logic rst, input logic [3:0] er, input logic [63:0] ed);
        cmp_t e;
        reset = rst; proc2mem_command = cmd; proc2mem_addr = addr; proc2mem_data = data;
        q_resp.push_back(er);
        if (rst) begin
            while (q_cmp.size() > 0 && q_cmp[q_cmp.size()-1].due > cnt) void'(q_cmp.pop_back());
        end
        if (er != 4'd0) begin
            e.due = cnt + LAT; e.tag = er; e.data = ed;
            q_cmp.push_back(e);
        end
        m_lfsr = rst ? 8'h01 : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        @(posedge clock); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(NONE, 32'd0, 64'd0, 1'b0, 4'd0, 64'd0);
    endtask

    always @(negedge clock) begin
        logic [3:0]  er, et;
        logic [63:0] ed;
        cmp_t        e;
        if (q_resp.size() > 0) begin
            er = q_resp.pop_front();
            chk("response", {60'd0, w_resp}, {60'd0, er});
            et = 4'd0; ed = 64'd0;
            if (q_cmp.size() > 0 && q_cmp[0].due == cnt) begin
                e = q_cmp.pop_front();
                et = e.tag; ed = e.data;
            end
            chk("cpl_tag", {60'd0, w_tag}, {60'd0, et});
            chk("cpl_data", w_data, ed);
        end
    end

`ifdef MEM_TAG_RESPONDER_REJECT_INJECT_EN
    logic [15:0] m_busy;
    int          m_due[16];

    task automatic inj(input logic [1:0] cmd, input logic [31:0] addr, input logic [63:0] d,
                       output logic acc);
        logic [3:0] t;
        t = 4'd0;
        for (int i = 1; i <= 15; i++) if (m_busy[i] && m_due[i] < cnt) m_busy[i] = 1'b0;
        for (int i = 15; i >= 1; i--) if (!m_busy[i]) t = 4'(i);
        if (m_lfsr[0]) t = 4'd0;
        acc = (t != 4'd0);
        if (acc) begin m_busy[t] = 1'b1; m_due[t] = cnt + LAT; end
        cyc(cmd, addr, d, 1'b0, t, d);
    endtask
`endif

    initial begin
        int   kk, tries;
        logic acc;
        reset = 1'b1; proc2mem_command = NONE; proc2mem_addr = '0; proc2mem_data = '0; sel = 1'b0;
        @(posedge clock); #1;
        cyc(LOAD, 32'h100, 64'd0, 1'b1, 4'd0, 64'd0);
        cyc(NONE, 32'd0, 64'd0, 1'b1, 4'd0, 64'd0);
`ifdef MEM_TAG_RESPONDER_REJECT_INJECT_EN
        m_busy = '0;
        kk = 0; tries = 0;
        while (kk < 8 && tries < 100) begin
            inj(STORE, 32'h400 + 32'(8 * kk), dk(kk + 20), acc);
            if (acc) kk++;
            tries++;
        end
        chk("inject_stores_done", 64'(kk), 64'd8);
        for (int i = 0; i < 32; i++) inj(LOAD, 32'h400 + 32'(8 * (i % 8)), dk((i % 8) + 20), acc);
        idle(6);
`else
        // store then load the same block
        cyc(STORE, 32'h100, 64'hDEAD_BEEF_0123_4567, 1'b0, 4'd1, 64'hDEAD_BEEF_0123_4567);
        cyc(LOAD,  32'h100, 64'd0, 1'b0, 4'd2, 64'hDEAD_BEEF_0123_4567);
        idle(5);
        // back-to-back: tag 1 comes back in the sixth cycle
        begin
            logic [3:0] et[6];
            et = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1};
            for (int k = 0; k < 6; k++) cyc(STORE, 32'h200 + 32'(8 * k), dk(k), 1'b0, et[k], dk(k));
            idle(5);
            for (int k = 0; k < 6; k++) cyc(LOAD, 32'h200 + 32'(9 * k), 64'd0, 1'b0, et[k], dk(k));
            idle(5);
        end
        // out-of-range and command 3 are rejected without consuming a tag
        cyc(LOAD,  32'h0001_0000, 64'd0, 1'b0, 4'd0, 64'd0);
        cyc(2'd3,  32'h100, 64'd0, 1'b0, 4'd0, 64'd0);
        cyc(STORE, 32'h0001_0008, 64'h1, 1'b0, 4'd0, 64'd0);
        cyc(LOAD,  32'h103, 64'd0, 1'b0, 4'd1, 64'hDEAD_BEEF_0123_4567);
        idle(5);
        // reset drops in-flight work but keeps the stored word
        cyc(STORE, 32'h40, 64'h0BAD_F00D_CAFE_1234, 1'b0, 4'd1, 64'h0BAD_F00D_CAFE_1234);
        cyc(LOAD,  32'h40, 64'd0, 1'b0, 4'd2, 64'h0BAD_F00D_CAFE_1234);
        cyc(LOAD,  32'h40, 64'd0, 1'b1, 4'd0, 64'd0);
        cyc(LOAD,  32'h40, 64'd0, 1'b0, 4'd1, 64'h0BAD_F00D_CAFE_1234);
        idle(6);
        // two-tag instance: exhaustion until tag 1 frees
        cyc(NONE, 32'd0, 64'd0, 1'b1, 4'd0, 64'd0);
        sel = 1'b1;
        cyc(NONE, 32'd0, 64'd0, 1'b1, 4'd0, 64'd0);
        cyc(STORE, 32'h300, 64'h7777_8888_9999_AAAA, 1'b0, 4'd1, 64'h7777_8888_9999_AAAA);
        cyc(LOAD,  32'h300, 64'd0, 1'b0, 4'd2, 64'h7777_8888_9999_AAAA);
        repeat (3) cyc(LOAD, 32'h300, 64'd0, 1'b0, 4'd0, 64'd0);
        cyc(LOAD,  32'h300, 64'd0, 1'b0, 4'd1, 64'h7777_8888_9999_AAAA);
        cyc(LOAD,  32'h300, 64'd0, 1'b0, 4'd2, 64'h7777_8888_9999_AAAA);
        idle(6);
`endif
        chk("pending_completions", 64'(q_cmp.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
